// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative unsigned multiplier (MULTU) that owns HI/LO.
//
// A MULTU accepted in IDLE runs WIDTH/BITS_PER_CYCLE RUN cycles. Each cycle
// retires BITS_PER_CYCLE shift-add steps on the {acc, mplier} product register.
// The full 2*WIDTH product is committed into HI/LO on the last RUN cycle.
//
// Optional feature macro: MUL_EARLY_EXIT_EN. When it is defined, the unit
// commits as soon as all multiplier bits not yet retired are zero.
//
// Ports:
//   clk, reset     - clock; synchronous active-high reset (aborts any multiply)
//   start          - MULTU issue; accepted only in IDLE
//   a, b           - multiplicand / multiplier, sampled on accepted start
//   read, lohi     - mfhi/mflo request and HI(1)/LO(0) select
//   result         - lohi ? hi : lo (combinational)
//   busy           - multiply in flight
//   stall          - busy & (start | read), holds the issuing instruction
module mul_sequencer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             read,
  input  logic             lohi,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             stall
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH:0]   acc_q,    acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;

  // Product register after this cycle's shift-add steps.
  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] mp_n;
  logic [2*WIDTH:0] prod_n;
  logic             done;

`ifdef MUL_EARLY_EXIT_EN
  logic [31:0]      rem_steps;  // steps still to retire after this cycle
  logic             rem_nz;     // some unretired multiplier bit is set
  logic [2*WIDTH:0] prod_sh;
`endif

  assign busy   = (state_q == RUN);
  assign stall  = busy & (start | read);
  assign result = lohi ? hi_q : lo_q;

  always_comb begin
    acc_n = acc_q;
    mp_n  = mplier_q;
    for (int s = 0; s < BITS_PER_CYCLE; s++) begin
      // acc has a zero top bit after every shift, so the WIDTH+1 bit sum keeps the carry.
      if (mp_n[0]) acc_n = acc_n + {1'b0, mcand_q};
      {acc_n, mp_n} = {1'b0, acc_n, mp_n[WIDTH-1:1]};
    end
    prod_n = {acc_n, mp_n};
  end

`ifdef MUL_EARLY_EXIT_EN
  always_comb begin
    rem_steps = (32'(count_q) - 32'd1) * 32'(BITS_PER_CYCLE);
    rem_nz    = 1'b0;
    // The low rem_steps bits of mplier are the multiplier bits not yet consumed.
    for (int i = 0; i < WIDTH; i++)
      if (32'(i) < rem_steps && mp_n[i]) rem_nz = 1'b1;
    // With no multiplier bits left, the remaining steps are plain shifts.
    prod_sh = prod_n >> rem_steps;
    done    = (count_q == CW'(1)) || !rem_nz;
  end
`else
  always_comb done = (count_q == CW'(1));
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          count_d  = CW'(N);
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_n;
        mplier_d = mp_n;
        count_d  = count_q - CW'(1);
        if (done) begin
`ifdef MUL_EARLY_EXIT_EN
          hi_d = prod_sh[2*WIDTH-1:WIDTH];
          lo_d = prod_sh[WIDTH-1:0];
`else
          hi_d = prod_n[2*WIDTH-1:WIDTH];
          lo_d = prod_n[WIDTH-1:0];
`endif
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer. Two instances, BITS_PER_CYCLE=1 and 4, receive the
// same stimulus. A cycle-level model predicts HI/LO, busy, stall and result.
// Directed vectors also carry hand-computed literal expectations.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, read, lohi;
  logic [31:0] a, b;
  logic [31:0] result1, result4;
  logic        busy1, busy4, stall1, stall4;

  int total = 0;
  int bad   = 0;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .read(read),
    .lohi(lohi), .result(result1), .busy(busy1), .stall(stall1));

  mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .read(read),
    .lohi(lohi), .result(result4), .busy(busy4), .stall(stall4));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Latency in cycles: N normally; with early exit, the first cycle k after
  // which the multiplier bits not yet retired (b >> k*bpc) are all zero.
  function automatic int lat(input logic [31:0] bv, input int bpc);
    if (EE) begin
      for (int k = 1; k <= 32 / bpc; k++)
        if ((bv >> (k * bpc)) == 32'd0) return k;
    end
    return 32 / bpc;
  endfunction

  // Model: index 0 -> bpc 1, index 1 -> bpc 4.
  logic [63:0] m_prod [2];
  logic [31:0] m_hi   [2];
  logic [31:0] m_lo   [2];
  int          m_rem  [2];
  bit          m_rdy = 1'b0;

  always @(posedge clk) begin
    if (reset) m_rdy <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_hi[i] <= 32'd0; m_lo[i] <= 32'd0; m_rem[i] <= 0;
      end else if (m_rem[i] > 0) begin
        m_rem[i] <= m_rem[i] - 1;
        if (m_rem[i] == 1) begin
          m_hi[i] <= m_prod[i][63:32];
          m_lo[i] <= m_prod[i][31:0];
        end
      end else if (start) begin
        m_prod[i] <= {32'd0, a} * {32'd0, b};
        m_rem[i]  <= lat(b, (i == 0) ? 1 : 4);
      end
    end
  end

  always @(negedge clk) begin
    if (m_rdy) begin
      chk("busy1",   32'(busy1),  32'(m_rem[0] > 0));
      chk("busy4",   32'(busy4),  32'(m_rem[1] > 0));
      chk("stall1",  32'(stall1), 32'((m_rem[0] > 0) && (start || read)));
      chk("stall4",  32'(stall4), 32'((m_rem[1] > 0) && (start || read)));
      chk("result1", result1, lohi ? m_hi[0] : m_lo[0]);
      chk("result4", result4, lohi ? m_hi[1] : m_lo[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one MULTU and wait, within a bound, for both units to finish.
  task automatic run_mul(input string nm, input logic [31:0] av, input logic [31:0] bv,
                         input bit rd, input int l1, input int l4);
    int c1, c4, st, n;
    a = av; b = bv; start = 1'b1; read = rd; lohi = rd;
    step();
    start = 1'b0;
    c1 = 0; c4 = 0; st = 0; n = 0;
    while ((busy1 || busy4) && n < 200) begin
      if (busy1) c1++;
      if (busy4) c4++;
      if (stall1) st++;
      n++;
      step();
    end
    chk({nm, "_lat1"}, 32'(c1), 32'(l1));
    chk({nm, "_lat4"}, 32'(c4), 32'(l4));
    if (rd) chk({nm, "_stallcyc"}, 32'(st), 32'(l1));
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] elo, input logic [31:0] ehi);
    read = 1'b1; lohi = 1'b0; #1;
    chk({nm, "_lo1"}, result1, elo);
    chk({nm, "_lo4"}, result4, elo);
    lohi = 1'b1; #1;
    chk({nm, "_hi1"}, result1, ehi);
    chk({nm, "_hi4"}, result4, ehi);
    read = 1'b0; lohi = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; read = 1'b0; lohi = 1'b0; a = '0; b = '0;
    step(); step();
    reset = 1'b0;

    read = 1'b1; lohi = 1'b0; #1;
    chk("rst_result_lo", result1, 32'd0);
    chk("rst_stall", 32'(stall1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    lohi = 1'b1; #1;
    chk("rst_result_hi", result1, 32'd0);
    read = 1'b0;
    step();

    run_mul("3x5", 32'd3, 32'd5, 1'b0, EE ? 3 : 32, EE ? 1 : 8);
    rd_chk("3x5", 32'h0000000F, 32'h0);
    // Issued in the first IDLE cycle: must be accepted with no bubble.
    run_mul("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32, 8);
    rd_chk("max", 32'h00000001, 32'hFFFFFFFE);

    run_mul("stall", 32'h00010000, 32'h00010000, 1'b1, EE ? 17 : 32, EE ? 5 : 8);
    #1;
    chk("stall_after", 32'(stall1), 32'd0);
    chk("stall_hi1", result1, 32'h00000001);
    chk("stall_hi4", result4, 32'h00000001);
    lohi = 1'b0; #1;
    chk("stall_lo1", result1, 32'h0);
    read = 1'b0;

    // Reset on the 10th RUN cycle aborts the multiply and clears HI/LO.
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("midrun_busy", 32'(busy1), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd0);
    rd_chk("abort", 32'h0, 32'h0);

    run_mul("7x9", 32'd7, 32'd9, 1'b0, EE ? 4 : 32, EE ? 1 : 8);
    rd_chk("7x9", 32'd63, 32'h0);
    run_mul("7x2", 32'd7, 32'd2, 1'b0, EE ? 2 : 32, EE ? 1 : 8);
    rd_chk("7x2", 32'h0000000E, 32'h0);
    run_mul("7x0", 32'd7, 32'd0, 1'b0, EE ? 1 : 32, EE ? 1 : 8);
    rd_chk("7x0", 32'h0, 32'h0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
